// File: rtl/core_pkg.sv
// Shared core definitions: opcode classes, condition codes, ID-stage state.
package core_pkg;

    localparam logic [4:0] NOP_OPCODE = 5'b11111;

    localparam logic [2:0] DP_REG = 3'b000;
    localparam logic [2:0] DP_IMM = 3'b001;
    localparam logic [2:0] LS_IMM = 3'b010;
    localparam logic [2:0] LS_REG = 3'b011;
    localparam logic [2:0] BRANCH = 3'b101;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic {
        RUN,
        STALL
    } id_state_t;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_t;

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluator: NZCV flags against a 4-bit condition field.
module cond_check
    import core_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        unique case (cond_t'(cond))
            EQ: pass = z;
            NE: pass = ~z;
            CS: pass = c;
            CC: pass = ~c;
            MI: pass = n;
            PL: pass = ~n;
            VS: pass = v;
            VC: pass = ~v;
            HI: pass = c & ~z;
            LS: pass = ~c | z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = ~z & (n == v);
            LE: pass = z | (n != v);
            AL: pass = 1'b1;
            NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_decode_issue.sv
// ID-stage decode/issue: IF/ID register, field split, load-use stall, flush.
// Define ID_COND_EVAL_EN to turn failing conditional instructions into bubbles.
module id_decode_issue
    import core_pkg::*;
#(
    parameter int STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_instr,
    input  logic        IF_valid,
    input  logic [3:0]  EXE_Rd_num,
    input  logic        EXE_load,
    input  logic        branch_taken,
    input  logic [3:0]  flags,
    input  logic [31:0] RF_A,
    input  logic [31:0] RF_B,
    output logic [3:0]  Rn_num,
    output logic [3:0]  Rm_num,
    output logic [31:0] ID_A,
    output logic [31:0] ID_B,
    output logic [11:0] ID_immed,
    output logic [4:0]  ID_Opcode,
    output logic [3:0]  ID_Rd_num,
    output logic [2:0]  ID_I_cmd,
    output logic        ID_S,
    output logic        ID_valid,
    output logic        IF_stall
);

    logic [31:0] ir;
    logic        ir_valid;
    id_state_t   state, state_n;
    logic [1:0]  cnt, cnt_n;

    logic [2:0]  i_cmd;
    logic [3:0]  dp_op;
    logic [4:0]  opcode;
    logic        is_ls, is_dp, store;
    logic        uses_rn, uses_rm;
    logic        cond_pass, live, hazard, issue;

    assign i_cmd = ir[27:25];
    assign dp_op = ir[24:21];
    assign is_ls = (i_cmd[2:1] == 2'b01);
    assign is_dp = (i_cmd[2:1] == 2'b00);
    assign store = is_ls & ~ir[20];

    // Stores read their data register through the Rm port.
    assign Rn_num = ir[19:16];
    assign Rm_num = store ? ir[15:12] : ir[3:0];

    assign opcode = is_ls ? {1'b1, ir[24:22], ir[20]}
                          : {1'b0, dp_op};

    assign uses_rn = ~(is_dp & ((dp_op == OP_MOV) | (dp_op == OP_MVN)));
    assign uses_rm = (i_cmd == DP_REG) | (i_cmd == LS_REG) | store;

`ifdef ID_COND_EVAL_EN
    cond_check u_cond_check (
        .flags (flags),
        .cond  (ir[31:28]),
        .pass  (cond_pass)
    );
`else
    logic unused_cond;
    assign unused_cond = ^{flags, ir[31:28]};
    assign cond_pass   = 1'b1;
`endif

    assign live   = ir_valid & cond_pass;
    assign hazard = live & EXE_load &
                    ((uses_rn & (Rn_num == EXE_Rd_num)) |
                     (uses_rm & (Rm_num == EXE_Rd_num)));

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        issue    = 1'b0;
        IF_stall = 1'b0;
        if (branch_taken) begin
            state_n = RUN;
            cnt_n   = 2'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hazard) begin
                        IF_stall = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_n = STALL;
                            cnt_n   = 2'(STALL_CYCLES - 2);
                        end
                    end else begin
                        issue = live;
                    end
                end
                STALL: begin
                    IF_stall = 1'b1;
                    if (cnt == 2'd0) state_n = RUN;
                    else             cnt_n   = cnt - 2'd1;
                end
            endcase
        end
    end

    assign ID_valid  = issue;
    assign ID_Opcode = issue ? opcode : NOP_OPCODE;
    assign ID_S      = issue & ir[20];
    assign ID_I_cmd  = issue ? i_cmd : 3'd0;
    assign ID_Rd_num = issue ? ir[15:12] : 4'd0;
    assign ID_immed  = issue ? ir[11:0] : 12'd0;
    assign ID_A      = RF_A;
    assign ID_B      = RF_B;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir       <= 32'd0;
            ir_valid <= 1'b0;
            state    <= RUN;
            cnt      <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (!IF_stall) begin
                ir       <= IF_instr;
                ir_valid <= IF_valid;
            end
        end
    end

endmodule

// File: tb/tb_id_decode_issue.sv
// Directed bench for id_decode_issue (STALL_CYCLES=2) with an expectation queue.
module tb_id_decode_issue;

    typedef struct packed {
        logic        v;
        logic [4:0]  op;
        logic        st;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rd;
        logic [2:0]  ic;
        logic        s;
        logic [11:0] imm;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    localparam logic [31:0] ADD_R1_R2_R3 = 32'hE0821003;
    localparam logic [31:0] MOV_R4_5     = 32'hE3A04005;
    localparam logic [31:0] LDR_R5_R6_8  = 32'hE5965008;
    localparam logic [31:0] STR_R7_R2_4  = 32'hE5827004;
    localparam logic [31:0] ADDS_R1_R2_1 = 32'hE2921001;
    localparam logic [31:0] ADDEQ        = 32'h00821003;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_instr;
    logic        IF_valid;
    logic [3:0]  EXE_Rd_num;
    logic        EXE_load;
    logic        branch_taken;
    logic [3:0]  flags;
    logic [31:0] RF_A, RF_B;
    logic [3:0]  Rn_num, Rm_num;
    logic [31:0] ID_A, ID_B;
    logic [11:0] ID_immed;
    logic [4:0]  ID_Opcode;
    logic [3:0]  ID_Rd_num;
    logic [2:0]  ID_I_cmd;
    logic        ID_S, ID_valid, IF_stall;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    id_decode_issue #(.STALL_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .IF_instr     (IF_instr),
        .IF_valid     (IF_valid),
        .EXE_Rd_num   (EXE_Rd_num),
        .EXE_load     (EXE_load),
        .branch_taken (branch_taken),
        .flags        (flags),
        .RF_A         (RF_A),
        .RF_B         (RF_B),
        .Rn_num       (Rn_num),
        .Rm_num       (Rm_num),
        .ID_A         (ID_A),
        .ID_B         (ID_B),
        .ID_immed     (ID_immed),
        .ID_Opcode    (ID_Opcode),
        .ID_Rd_num    (ID_Rd_num),
        .ID_I_cmd     (ID_I_cmd),
        .ID_S         (ID_S),
        .ID_valid     (ID_valid),
        .IF_stall     (IF_stall)
    );

    function automatic exp_t issue_e(logic [4:0] op, logic [3:0] rn,
                                     logic [3:0] rm, logic [3:0] rd,
                                     logic [2:0] ic, logic s,
                                     logic [11:0] imm);
        exp_t e;
        e = '{v: 1'b1, op: op, st: 1'b0, rn: rn, rm: rm, rd: rd,
              ic: ic, s: s, imm: imm, a: RF_A, b: RF_B};
        return e;
    endfunction

    function automatic exp_t bubble_e(logic st, logic [3:0] rn,
                                      logic [3:0] rm);
        exp_t e;
        e = '{v: 1'b0, op: 5'b11111, st: st, rn: rn, rm: rm, rd: 4'd0,
              ic: 3'd0, s: 1'b0, imm: 12'd0, a: RF_A, b: RF_B};
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t e, o;
        #1;
        o = '{v: ID_valid, op: ID_Opcode, st: IF_stall, rn: Rn_num,
              rm: Rm_num, rd: ID_Rd_num, ic: ID_I_cmd, s: ID_S,
              imm: ID_immed, a: ID_A, b: ID_B};
        total++;
        if (q.size() == 0) begin
            $error("FAIL %s: got %h required an expectation entry", tag, o);
        end else begin
            e = q.pop_front();
            assert (o === e) passed++;
            else $error("FAIL %s: got %h required %h", tag, o, e);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic vld,
                         input logic ld, input logic [3:0] rd,
                         input logic br);
        @(negedge clk);
        IF_instr     = ins;
        IF_valid     = vld;
        EXE_load     = ld;
        EXE_Rd_num   = rd;
        branch_taken = br;
        RF_A         = $urandom;
        RF_B         = $urandom;
    endtask

    initial begin
        reset        = 1'b1;
        IF_instr     = 32'd0;
        IF_valid     = 1'b0;
        EXE_Rd_num   = 4'd0;
        EXE_load     = 1'b0;
        branch_taken = 1'b0;
        flags        = 4'b0000;
        RF_A         = 32'd0;
        RF_B         = 32'd0;

        drive(32'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        q.push_back(bubble_e(1'b0, 4'd0, 4'd0));
        check("reset_state");
        reset = 1'b0;

        drive(ADD_R1_R2_R3, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(bubble_e(1'b0, 4'd0, 4'd0));
        check("empty_ir");

        drive(MOV_R4_5, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(issue_e(5'b00100, 4'd2, 4'd3, 4'd1, 3'b000, 1'b0, 12'h003));
        check("add_issue");

        drive(ADD_R1_R2_R3, 1'b1, 1'b1, 4'd0, 1'b0);
        q.push_back(issue_e(5'b01101, 4'd0, 4'd5, 4'd4, 3'b001, 1'b0, 12'h005));
        check("mov_no_rn_hazard");

        drive(STR_R7_R2_4, 1'b1, 1'b1, 4'd2, 1'b0);
        q.push_back(bubble_e(1'b1, 4'd2, 4'd3));
        check("rn_hazard_bubble1");

        drive(STR_R7_R2_4, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(bubble_e(1'b1, 4'd2, 4'd3));
        check("rn_hazard_bubble2");

        drive(STR_R7_R2_4, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(issue_e(5'b00100, 4'd2, 4'd3, 4'd1, 3'b000, 1'b0, 12'h003));
        check("add_after_stall");

        drive(LDR_R5_R6_8, 1'b1, 1'b1, 4'd7, 1'b0);
        q.push_back(bubble_e(1'b1, 4'd2, 4'd7));
        check("store_data_hazard");

        drive(LDR_R5_R6_8, 1'b1, 1'b0, 4'd0, 1'b1);
        q.push_back(bubble_e(1'b0, 4'd2, 4'd7));
        check("flush_in_stall");

        drive(ADD_R1_R2_R3, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(issue_e(5'b11101, 4'd6, 4'd8, 4'd5, 3'b010, 1'b1, 12'h008));
        check("ldr_after_flush");

        drive(ADDS_R1_R2_1, 1'b1, 1'b1, 4'd2, 1'b1);
        q.push_back(bubble_e(1'b0, 4'd2, 4'd3));
        check("flush_on_hazard");

        drive(ADD_R1_R2_R3, 1'b0, 1'b0, 4'd0, 1'b0);
        q.push_back(issue_e(5'b00100, 4'd2, 4'd1, 4'd1, 3'b001, 1'b1, 12'h001));
        check("adds_new_fetch");

        drive(ADD_R1_R2_R3, 1'b1, 1'b1, 4'd2, 1'b0);
        q.push_back(bubble_e(1'b0, 4'd2, 4'd3));
        check("invalid_no_hazard");

        drive(MOV_R4_5, 1'b1, 1'b1, 4'd3, 1'b0);
        q.push_back(bubble_e(1'b1, 4'd2, 4'd3));
        check("rm_hazard");

        drive(MOV_R4_5, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(bubble_e(1'b1, 4'd2, 4'd3));
        check("rm_hazard_stall");

        drive(MOV_R4_5, 1'b1, 1'b1, 4'd2, 1'b0);
        q.push_back(bubble_e(1'b1, 4'd2, 4'd3));
        check("back_to_back_hazard");

        drive(MOV_R4_5, 1'b1, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        q.push_back(bubble_e(1'b0, 4'd0, 4'd0));
        check("reset_mid_stall");

        drive(ADD_R1_R2_R3, 1'b1, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        q.push_back(bubble_e(1'b0, 4'd0, 4'd0));
        check("after_reset");

        drive(ADDEQ, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(issue_e(5'b00100, 4'd2, 4'd3, 4'd1, 3'b000, 1'b0, 12'h003));
        check("refetch_issue");

`ifdef ID_COND_EVAL_EN
        flags = 4'b0000;
        drive(ADDEQ, 1'b1, 1'b1, 4'd2, 1'b0);
        q.push_back(bubble_e(1'b0, 4'd2, 4'd3));
        check("addeq_z0_bubble");

        flags = 4'b0100;
        drive(MOV_R4_5, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(issue_e(5'b00100, 4'd2, 4'd3, 4'd1, 3'b000, 1'b0, 12'h003));
        check("addeq_z1_issue");
`else
        flags = 4'b0000;
        drive(MOV_R4_5, 1'b1, 1'b0, 4'd0, 1'b0);
        q.push_back(issue_e(5'b00100, 4'd2, 4'd3, 4'd1, 3'b000, 1'b0, 12'h003));
        check("cond_ignored");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_decode_issue.md
# id_decode_issue

Decode-and-issue front end of the ID stage for the 5-stage core. Holds the IF/ID instruction register, splits the 32-bit instruction into the fields consumed by the ID/EXE pipeline register, and reads operands from the register file. It also detects load-use hazards against the instruction in EXE, inserts bubbles and stalls fetch, and squashes the held instruction on a taken branch. It is the producer end of the ID/EXE interface: its `ID_*` outputs wire directly to the ID/EXE register inputs.

## Interface

**Parameters**
- `STALL_CYCLES`, default 1: bubble cycles inserted per load-use hazard, range 1..3.

**Ports**
- `clk` in, 1: pipeline clock, rising edge.
- `reset` in, 1: asynchronous, active-high reset. One clock only.
- `IF_instr` in, 32: fetched instruction.
- `IF_valid` in, 1: `IF_instr` is real.
- `EXE_Rd_num` in, 4: destination of the instruction currently in EXE.
- `EXE_load` in, 1: the EXE instruction is a load that writes `EXE_Rd_num`.
- `branch_taken` in, 1: EXE resolved a taken branch; squash the ID instruction.
- `flags` in, 4: CPSR NZCV. Only used with `ID_COND_EVAL_EN`.
- `RF_A`, `RF_B` in, 32 each: register-file read data for `Rn_num` / `Rm_num`.
- `Rn_num`, `Rm_num` out, 4 each: register-file read addresses.
- `ID_A`, `ID_B` out, 32 each: operands, equal to `RF_A` / `RF_B`.
- `ID_immed` out, 12: `instr[11:0]`.
- `ID_Opcode` out, 5: class-qualified opcode.
- `ID_Rd_num` out, 4: `instr[15:12]`.
- `ID_I_cmd` out, 3: `instr[27:25]`.
- `ID_S` out, 1: `instr[20]`.
- `ID_valid` out, 1: a real instruction is being issued this cycle.
- `IF_stall` out, 1: hold the PC and do not advance `IF_instr`.

## Operation

**Instruction register**
- Internal `ir` (32 bits) and `ir_valid`. Both load from `IF_instr` / `IF_valid` on every edge where `IF_stall` is 0.

**Field decode**
- `Rn_num` = `ir[19:16]`.
- `Rm_num` = `ir[3:0]`, except for stores (load/store class with `L`=0), where `Rm_num` = `ir[15:12]` so the store data is read.
- `ID_Opcode[4]` = 1 for the load/store class (`I_cmd[2:1]` = 01).
- `ID_Opcode[3:0]`:
  - load/store class: {P, U, B, L} = {`ir[24]`, `ir[23]`, `ir[22]`, `ir[20]`}.
  - otherwise: `ir[24:21]`.

**Source usage**
- `uses_rn`: every instruction except data-processing MOV/MVN (opcode 1101/1111).
- `uses_rm`: data-processing with `I_cmd` = 000, load/store with `I_cmd` = 011, and all stores.

**Hazard**
- `hazard` = `ir_valid` & `EXE_load` & ((`uses_rn` & `Rn_num` == `EXE_Rd_num`) | (`uses_rm` & `Rm_num` == `EXE_Rd_num`)).

**Bubble**
- `ID_valid`=0, `ID_Opcode`=`NOP_OPCODE` (5'b11111), `ID_S`=0, `ID_I_cmd`=0, `ID_Rd_num`=0, `ID_immed`=0.
- `ID_A` / `ID_B` still follow the register-file data; they are don't-care.

**State machine (`RUN`, `STALL`)**
- `RUN`, no hazard: issue `ir`, `ID_valid`=`ir_valid`, `IF_stall`=0.
- `RUN`, hazard: drive a bubble, `IF_stall`=1.
  - If `STALL_CYCLES` > 1: go to `STALL` with `cnt` = `STALL_CYCLES`−2.
  - Otherwise: stay in `RUN`.
- `STALL`: drive a bubble, `IF_stall`=1.
  - `cnt`=0: go to `RUN`.
  - otherwise: decrement `cnt`.
- `STALL` never re-evaluates the hazard, because EXE now holds a bubble.

**Flush**
- `branch_taken`=1 overrides every other condition, in any state:
  - This cycle: outputs are a bubble and `IF_stall`=0.
  - Next edge: `ir_valid` ← `IF_valid` of the new fetch, state ← `RUN`, `cnt` ← 0.
- A flush that coincides with a hazard produces no stall.

## Timing

- **Reset** (asynchronous, immediate): `ir`=0, `ir_valid`=0, state `RUN`, `cnt`=0. Outputs show a bubble, `IF_stall`=0, `Rn_num`=`Rm_num`=0.
- Decode, operand and hazard paths are combinational from `ir`. An instruction captured at edge N appears on `ID_*` during cycle N and is captured by ID/EXE at edge N+1.
- A load-use hazard costs exactly `STALL_CYCLES` bubbles. The dependent instruction issues in cycle N+`STALL_CYCLES`.
- Back-to-back hazards (the instruction after the stall also depends on a load) each incur the full stall.
- `reset` asserted mid-stall aborts the stall. The held instruction is lost; IF is responsible for refetching it.
- `IF_valid`=0 captured into `ir` behaves as a bubble and never raises a hazard.

## Configuration

- Macro `ID_COND_EVAL_EN`.
- **Defined:** evaluate `ir[31:28]` against `flags` (EQ..AL, with NV treated as never). A failing condition turns the instruction into a bubble with `IF_stall`=0. A failing instruction cannot raise a hazard.
- **Undefined:** `flags` is unused, the condition field is ignored, and every valid instruction issues.

## Structure

- Shared package `core_pkg` holds:
  - `NOP_OPCODE`
  - `I_cmd` class constants (DP_REG=000, DP_IMM=001, LS_IMM=010, LS_REG=011, BRANCH=101)
  - MOV/MVN opcode constants
  - the `id_state_t` enum {`RUN`, `STALL`}
  - the condition-code enum.
- One sub-module is natural: `cond_check` (combinational, NZCV × cond → pass). It is instantiated only under `ID_COND_EVAL_EN`.

## Test plan

- Reset mid-operation with `ir` loaded → outputs are a bubble immediately, `IF_stall`=0, `ID_Opcode`=5'b11111.
- ADD R1,R2,R3 (0xE0821003) with no hazard → `ID_Opcode`=5'b00100, `ID_I_cmd`=000, `Rn_num`=2, `Rm_num`=3, `ID_Rd_num`=1, `ID_valid`=1 in the same cycle.
- `EXE_load`=1, `EXE_Rd_num`=2, ID holds ADD R1,R2,R3, `STALL_CYCLES`=2 → 2 bubble cycles with `IF_stall`=1, then the ADD issues with `ID_valid`=1.
- Same hazard but `branch_taken`=1 in the hazard cycle → bubble output, `IF_stall`=0, next cycle `ir` holds the new fetch.
- MOV R4,#5 (0xE3A04005) with `EXE_load`=1, `EXE_Rd_num`=0 → no stall (Rn is unused).
- With `ID_COND_EVAL_EN` defined: ADDEQ with Z=0 → bubble, no stall. Z=1 → issues normally.
